// File: rtl/universal_mode_register_if.sv
`default_nettype none
// ============================================================================
// Module   : universal_mode_register_if
// Purpose  : Control/data bundle for the universal mode register. The master
//            side drives the mode controls and load data; the slave side (the
//            register) returns the registered value and its status flags.
// Ports    : en, sel, in, shamt, serial_in  (master -> slave)
//            out, carry, zero               (slave -> master)
// Revision : 1.0 - initial release
// ============================================================================
interface universal_mode_register_if #(
  parameter int WIDTH = 16
);
  localparam int SHW = $clog2(WIDTH);

  logic             en;
  logic [2:0]       sel;
  logic [WIDTH-1:0] in;
  logic [SHW-1:0]   shamt;
  logic             serial_in;
  logic [WIDTH-1:0] out;
  logic             carry;
  logic             zero;

  modport master (
    output en, sel, in, shamt, serial_in,
    input  out, carry, zero
  );

  modport slave (
    input  en, sel, in, shamt, serial_in,
    output out, carry, zero
  );
endinterface
`default_nettype wire

// File: rtl/universal_mode_register.sv
`default_nettype none
// ============================================================================
// Module   : universal_mode_register
// Purpose  : General-purpose working register with eight modes: hold, load,
//            logical shift left/right with serial fill, rotate left/right,
//            increment and decrement by STEP. Variable shift amount, cycle
//            enable and registered carry/zero status flags.
// Ports    : clock     - system clock, rising edge
//            reset     - asynchronous, active-high reset
//            bus       - slave side of universal_mode_register_if
//                        (en, sel, in, shamt, serial_in / out, carry, zero)
// Revision : 1.0 - initial release
// ============================================================================
module universal_mode_register #(
  parameter int               WIDTH     = 16,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int               STEP      = 1
) (
  input  wire logic                     clock,
  input  wire logic                     reset,
  universal_mode_register_if.slave      bus
);

  localparam int SHW    = $clog2(WIDTH);
  localparam int SHW_P1 = SHW + 1;

  localparam logic [2:0] c_sel_hold = 3'b000;
  localparam logic [2:0] c_sel_load = 3'b001;
  localparam logic [2:0] c_sel_shl  = 3'b010;
  localparam logic [2:0] c_sel_shr  = 3'b011;
  localparam logic [2:0] c_sel_rol  = 3'b100;
  localparam logic [2:0] c_sel_ror  = 3'b101;
  localparam logic [2:0] c_sel_inc  = 3'b110;
  localparam logic [2:0] c_sel_dec  = 3'b111;

  localparam logic [WIDTH-1:0] c_ones      = '1;
  localparam logic [WIDTH-1:0] c_one       = WIDTH'(1);
  localparam logic [WIDTH-1:0] c_step      = WIDTH'(STEP);
  localparam logic [SHW:0]     c_width_ext = SHW_P1'(WIDTH);

  logic [WIDTH-1:0] r_out;
  logic             r_carry;
  logic             r_zero;

  logic [WIDTH-1:0] w_next_out;
  logic             w_next_carry;

  logic             w_shamt_nz;
  logic [SHW:0]     w_inv;        // WIDTH - shamt, one bit wider so WIDTH fits
  logic [WIDTH-1:0] w_fill_lo;    // low shamt bits set
  logic [WIDTH-1:0] w_fill_hi;    // high shamt bits set
  logic [WIDTH-1:0] w_shl;
  logic [WIDTH-1:0] w_shr;
  logic [WIDTH-1:0] w_rol;
  logic [WIDTH-1:0] w_ror;
  logic [WIDTH-1:0] w_shl_tap;    // one-hot at bit WIDTH-shamt
  logic [WIDTH-1:0] w_shr_tap;    // one-hot at bit shamt-1
  logic [WIDTH:0]   w_inc;
  logic [WIDTH:0]   w_dec;

  assign w_shamt_nz = |bus.shamt;
  assign w_inv      = c_width_ext - {1'b0, bus.shamt};

  assign w_fill_lo = ~(c_ones << bus.shamt);
  assign w_fill_hi = ~(c_ones >> bus.shamt);

  assign w_shl = (r_out << bus.shamt) | (bus.serial_in ? w_fill_lo : '0);
  assign w_shr = (r_out >> bus.shamt) | (bus.serial_in ? w_fill_hi : '0);

  // With shamt = 0 the wrap-around term shifts by WIDTH and vanishes.
  assign w_rol = (r_out << bus.shamt) | (r_out >> w_inv);
  assign w_ror = (r_out >> bus.shamt) | (r_out << w_inv);

  // Last bit shifted out. Both taps are meaningless at shamt = 0, where the
  // carry is forced low anyway.
  assign w_shl_tap = c_one << w_inv;
  assign w_shr_tap = (c_one << bus.shamt) >> 1;

  // Bit WIDTH of each result is the carry (INC) or borrow (DEC).
  assign w_inc = {1'b0, r_out} + {1'b0, c_step};
  assign w_dec = {1'b0, r_out} - {1'b0, c_step};

  always_comb begin
    w_next_out   = r_out;
    w_next_carry = r_carry;
    if (bus.en) begin
      case (bus.sel)
        c_sel_hold: begin
          w_next_out   = r_out;
          w_next_carry = r_carry;
        end
        c_sel_load: begin
          w_next_out   = bus.in;
          w_next_carry = 1'b0;
        end
        c_sel_shl: begin
          w_next_out   = w_shl;
          w_next_carry = w_shamt_nz & (|(r_out & w_shl_tap));
        end
        c_sel_shr: begin
          w_next_out   = w_shr;
          w_next_carry = w_shamt_nz & (|(r_out & w_shr_tap));
        end
        c_sel_rol: begin
          w_next_out   = w_rol;
          w_next_carry = w_shamt_nz & w_rol[0];
        end
        c_sel_ror: begin
          w_next_out   = w_ror;
          w_next_carry = w_shamt_nz & w_ror[WIDTH-1];
        end
        c_sel_inc: begin
          w_next_out   = w_inc[WIDTH-1:0];
          w_next_carry = w_inc[WIDTH];
        end
        c_sel_dec: begin
          w_next_out   = w_dec[WIDTH-1:0];
          w_next_carry = w_dec[WIDTH];
        end
        default: begin
          w_next_out   = r_out;
          w_next_carry = r_carry;
        end
      endcase
    end
  end

  // The zero flag is registered from the next value so it always tracks out.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_out   <= RESET_VAL;
      r_carry <= 1'b0;
      r_zero  <= (RESET_VAL == '0);
    end else begin
      r_out   <= w_next_out;
      r_carry <= w_next_carry;
      r_zero  <= (w_next_out == '0);
    end
  end

  assign bus.out   = r_out;
  assign bus.carry = r_carry;
  assign bus.zero  = r_zero;

endmodule
`default_nettype wire
